// File: rtl/seg7_scan_mux.sv
`default_nettype none
// ============================================================================
// Module  : seg7_scan_mux
// Brief   : Time-multiplexed 7-segment scanner with raw/hex modes and
//           anti-ghosting blank window at the start of each digit slot.
// Revision: 1.0 - initial release
// ============================================================================
module seg7_scan_mux #(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 16,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    mode,
    input  logic [8*NUM_DIGITS-1:0] raw_seg,
    input  logic [4*NUM_DIGITS-1:0] hex_val,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_tick
);

    localparam int c_CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int c_IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(SCAN_DIV - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_MAX = c_IDX_W'(NUM_DIGITS - 1);
    localparam logic [c_CNT_W-1:0] c_BLANK   = c_CNT_W'(BLANK_CYCLES);
    localparam logic               c_POL     = (ACTIVE_LOW != 0);

    logic [c_CNT_W-1:0]    r_cnt;
    logic [c_IDX_W-1:0]    r_idx;
    logic [6:0]            r_seg;
    logic                  r_dp;
    logic [NUM_DIGITS-1:0] r_an;
    logic                  r_frame_tick;

    logic                  w_cnt_wrap;
    logic                  w_frame_wrap;
    logic [c_CNT_W-1:0]    w_cnt_nxt;
    logic [c_IDX_W-1:0]    w_idx_nxt;
    logic                  w_in_window;
    logic [7:0]            w_sel_raw;
    logic [3:0]            w_sel_hex;
    logic                  w_sel_dp;
    logic                  w_sel_blank;
    logic [NUM_DIGITS-1:0] w_onehot;
    logic                  w_digit_on;
    logic [6:0]            w_seg_hi;
    logic                  w_dp_hi;
    logic [NUM_DIGITS-1:0] w_an_hi;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    assign w_cnt_wrap   = (r_cnt == c_CNT_MAX);
    assign w_frame_wrap = w_cnt_wrap && (r_idx == c_IDX_MAX);
    assign w_cnt_nxt    = w_cnt_wrap ? '0 : r_cnt + 1'b1;
    assign w_idx_nxt    = !w_cnt_wrap ? r_idx :
                          (r_idx == c_IDX_MAX) ? '0 : r_idx + 1'b1;

    // Outputs are decoded from the post-edge counter values so they line up with cnt/idx.
    generate
        if (BLANK_CYCLES == 0) begin : g_no_blank
            assign w_in_window = 1'b1;
        end else begin : g_blank_window
            assign w_in_window = (w_cnt_nxt >= c_BLANK);
        end
    endgenerate

    always_comb begin
        w_sel_raw   = '0;
        w_sel_hex   = '0;
        w_sel_dp    = 1'b0;
        w_sel_blank = 1'b1;
        w_onehot    = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_idx_nxt == c_IDX_W'(i)) begin
                w_sel_raw   = raw_seg[8*i +: 8];
                w_sel_hex   = hex_val[4*i +: 4];
                w_sel_dp    = dp_in[i];
                w_sel_blank = blank[i];
                w_onehot[i] = 1'b1;
            end
        end
    end

    always_comb begin
        w_digit_on = w_in_window && !w_sel_blank;
        w_seg_hi   = '0;
        w_dp_hi    = 1'b0;
        w_an_hi    = '0;
        if (w_digit_on) begin
            w_an_hi  = w_onehot;
            w_seg_hi = mode ? hex_to_seg(w_sel_hex) : w_sel_raw[6:0];
            w_dp_hi  = mode ? w_sel_dp : w_sel_raw[7];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt        <= '0;
            r_idx        <= '0;
            r_frame_tick <= 1'b0;
            r_seg        <= {7{c_POL}};
            r_dp         <= c_POL;
            r_an         <= {NUM_DIGITS{c_POL}};
        end else begin
            r_cnt        <= w_cnt_nxt;
            r_idx        <= w_idx_nxt;
            r_frame_tick <= w_frame_wrap;
            r_seg        <= w_seg_hi ^ {7{c_POL}};
            r_dp         <= w_dp_hi ^ c_POL;
            r_an         <= w_an_hi ^ {NUM_DIGITS{c_POL}};
        end
    end

    assign seg        = r_seg;
    assign dp         = r_dp;
    assign an         = r_an;
    assign frame_tick = r_frame_tick;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_mux.sv
`default_nettype none
// ============================================================================
// Module  : tb_seg7_scan_mux
// Brief   : Scoreboard bench for seg7_scan_mux (active-low with blank window,
//           plus an active-high instance with no blank window).
// Revision: 1.0 - initial release
// ============================================================================
module tb_seg7_scan_mux;

    localparam int c_N     = 4;
    localparam int c_DIV   = 8;
    localparam int c_BLANK = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic        mode;
    logic [31:0] raw_seg;
    logic [15:0] hex_val;
    logic [3:0]  dp_in;
    logic [3:0]  blank;

    logic [6:0]  seg_a, seg_b;
    logic        dp_a, dp_b;
    logic [3:0]  an_a, an_b;
    logic        ft_a, ft_b;

    always #5 clock = ~clock;

    seg7_scan_mux #(
        .NUM_DIGITS(c_N), .SCAN_DIV(c_DIV), .BLANK_CYCLES(c_BLANK), .ACTIVE_LOW(1)
    ) u_dut_lo (
        .clock(clock), .reset(reset), .mode(mode), .raw_seg(raw_seg),
        .hex_val(hex_val), .dp_in(dp_in), .blank(blank),
        .seg(seg_a), .dp(dp_a), .an(an_a), .frame_tick(ft_a)
    );

    seg7_scan_mux #(
        .NUM_DIGITS(c_N), .SCAN_DIV(c_DIV), .BLANK_CYCLES(0), .ACTIVE_LOW(0)
    ) u_dut_hi (
        .clock(clock), .reset(reset), .mode(mode), .raw_seg(raw_seg),
        .hex_val(hex_val), .dp_in(dp_in), .blank(blank),
        .seg(seg_b), .dp(dp_b), .an(an_b), .frame_tick(ft_b)
    );

    typedef struct packed {
        logic [6:0] seg_a;
        logic       dp_a;
        logic [3:0] an_a;
        logic       ft;
        logic [6:0] seg_b;
        logic       dp_b;
        logic [3:0] an_b;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   t_model  = 0;
    int   n_ft     = 0;

    function automatic logic [6:0] ref_hex7(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
            4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
            4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
            4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
        endcase
        return s;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0d: got %h expected %h", tag, t_model, got, exp);
        end
    endtask

    // Reference counters are derived from the edge count since reset, not from a prescaler copy.
    task automatic predict();
        exp_t       e;
        int         c, d;
        logic [7:0] raw;
        logic [6:0] s;
        logic       p, on_a, on_b;
        if (reset) begin
            t_model = 0;
            e = '{seg_a: 7'h7F, dp_a: 1'b1, an_a: 4'hF, ft: 1'b0,
                  seg_b: 7'h00, dp_b: 1'b0, an_b: 4'h0};
        end else begin
            t_model++;
            c    = t_model % c_DIV;
            d    = (t_model / c_DIV) % c_N;
            e.ft = ((t_model % (c_DIV * c_N)) == 0);
            raw  = raw_seg[8*d +: 8];
            if (mode) begin
                s = ref_hex7(hex_val[4*d +: 4]);
                p = dp_in[d];
            end else begin
                s = raw[6:0];
                p = raw[7];
            end
            on_a    = (c >= c_BLANK) && !blank[d];
            on_b    = !blank[d];
            e.an_a  = on_a ? ~(4'b0001 << d) : 4'hF;
            e.seg_a = on_a ? ~s : 7'h7F;
            e.dp_a  = on_a ? ~p : 1'b1;
            e.an_b  = on_b ? (4'b0001 << d) : 4'h0;
            e.seg_b = on_b ? s : 7'h00;
            e.dp_b  = on_b ? p : 1'b0;
        end
        sb_q.push_back(e);
    endtask

    task automatic step();
        exp_t e;
        predict();
        @(posedge clock);
        #1;
        e = sb_q.pop_front();
        check("seg_lo", {25'd0, seg_a}, {25'd0, e.seg_a});
        check("dp_lo",  {31'd0, dp_a},  {31'd0, e.dp_a});
        check("an_lo",  {28'd0, an_a},  {28'd0, e.an_a});
        check("ft_lo",  {31'd0, ft_a},  {31'd0, e.ft});
        check("seg_hi", {25'd0, seg_b}, {25'd0, e.seg_b});
        check("dp_hi",  {31'd0, dp_b},  {31'd0, e.dp_b});
        check("an_hi",  {28'd0, an_b},  {28'd0, e.an_b});
        check("ft_hi",  {31'd0, ft_b},  {31'd0, e.ft});
        if (ft_a) n_ft++;
    endtask

    initial begin
        reset   = 1'b1;
        mode    = 1'b1;
        raw_seg = '0;
        hex_val = 16'h1234;
        dp_in   = 4'h0;
        blank   = 4'h0;
        repeat (3) step();

        // Hex mode, two full frames: exactly two frame ticks expected.
        reset = 1'b0;
        n_ft  = 0;
        repeat (64) step();
        check("frame_count", n_ft, 2);
        repeat (6) step();

        // Mid-slot data change.
        hex_val = 16'hABCD;
        dp_in   = 4'b0101;
        repeat (40) step();

        // Raw mode.
        mode    = 1'b0;
        raw_seg = {8'hC6, 8'h5B, 8'h3F, 8'h80};
        repeat (40) step();

        // Force-off of digit 1.
        blank = 4'b0010;
        repeat (40) step();
        blank = 4'b0000;

        // Reset for one edge at idx=2, cnt=5.
        mode = 1'b1;
        for (int k = 0; k < 40 && (t_model % 32) != 21; k++) step();
        check("reset_point", t_model % 32, 21);
        reset = 1'b1;
        step();
        reset = 1'b0;
        repeat (20) step();

        // Decoder sweep on every digit.
        blank = 4'h0;
        dp_in = 4'h0;
        for (int n = 0; n < 16; n++) begin
            hex_val = {4{n[3:0]}};
            repeat (8) step();
        end

        // Random traffic with inputs changing every cycle.
        for (int k = 0; k < 120; k++) begin
            mode    = 1'($urandom_range(0, 1));
            raw_seg = $urandom;
            hex_val = 16'($urandom);
            dp_in   = 4'($urandom);
            blank   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
